// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter multiplexing NREQ requesters onto one shared divider.
// Optional WAIT watchdog is compiled in when DIV_ARB_TIMEOUT_EN is defined.
module div_arbiter #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [SIZE-1:0]      res_m,
    output logic [9:0]           res_f,
    output logic                 res_err,
    output logic                 div_start,
    output logic [SIZE-1:0]      div_a,
    output logic [SIZE-1:0]      div_b,
    input  logic                 div_done,
    input  logic [SIZE-1:0]      div_m,
    input  logic [9:0]           div_f,
    input  logic                 div_err
);
    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("div_arbiter: NREQ must be 2..8 and TIMEOUT nonzero");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

    state_e        state_q;
    logic [IW-1:0] last_q;
    logic [IW-1:0] win_q;
    logic [IW-1:0] pick;
    logic          any_req;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_q;
`endif

    // Search starts just above the last served requester, wrapping at NREQ.
    always_comb begin
        logic [IW-1:0] idx;
        idx     = '0;
        pick    = last_q;
        any_req = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = IW'((int'(last_q) + k) % int'(NREQ));
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= IW'(NREQ - 1);
            win_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            res_m     <= '0;
            res_f     <= '0;
            res_err   <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            done      <= '0;
            div_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        win_q     <= pick;
                        gnt[pick] <= 1'b1;
                        div_a     <= req_a[pick*SIZE +: SIZE];
                        div_b     <= req_b[pick*SIZE +: SIZE];
                        div_start <= (req_b[pick*SIZE +: SIZE] != '0);
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (div_b != '0) begin
                        state_q <= StWait;
`ifdef DIV_ARB_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        // Divide by zero never reaches the divider.
                        res_m       <= '0;
                        res_f       <= '0;
                        res_err     <= 1'b1;
                        div_a       <= '0;
                        div_b       <= '0;
                        done[win_q] <= 1'b1;
                        state_q     <= StReturn;
                    end
                end
                StWait: begin
                    if (div_done) begin
                        res_m       <= div_m;
                        res_f       <= div_f;
                        res_err     <= div_err;
                        div_a       <= '0;
                        div_b       <= '0;
                        done[win_q] <= 1'b1;
                        state_q     <= StReturn;
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        res_m       <= '0;
                        res_f       <= '0;
                        res_err     <= 1'b1;
                        div_a       <= '0;
                        div_b       <= '0;
                        done[win_q] <= 1'b1;
                        state_q     <= StReturn;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                StReturn: begin
                    gnt     <= '0;
                    last_q  <= win_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: table + scoreboard bench for div_arbiter with a behavioural divider.
// Define DIV_ARB_TIMEOUT_EN for both files to exercise the watchdog path.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam int SIZE = 4;
    localparam int NREQ = 4;
    localparam int TMO  = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [SIZE-1:0]      res_m;
    logic [9:0]           res_f;
    logic                 res_err;
    logic                 div_start;
    logic [SIZE-1:0]      div_a;
    logic [SIZE-1:0]      div_b;
    logic                 div_done;
    logic [SIZE-1:0]      div_m = '0;
    logic [9:0]           div_f = '0;
    logic                 div_err = 1'b0;

    div_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .done      (done),
        .res_m     (res_m),
        .res_f     (res_f),
        .res_err   (res_err),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_m     (div_m),
        .div_f     (div_f),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int a; int b; int m; int f; int err;} vec_t;
    typedef struct {int idx; int m; int f; int err;} exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[8];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   starts = 0;
    int   dd_cyc = -1;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural divider: answers model_delay cycles after div_start unless disabled.
    logic            model_en = 1'b1;
    int              model_delay = 5;
    int              mcnt = 0;
    logic            model_done = 1'b0;
    logic            stray = 1'b0;
    logic [SIZE-1:0] ma = '0;
    logic [SIZE-1:0] mb = '0;
    assign div_done = model_done | stray;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        model_done <= 1'b0;
        if (div_start) begin
            mcnt <= model_delay;
            ma   <= div_a;
            mb   <= div_b;
        end else if (mcnt == 1) begin
            mcnt <= 0;
            if (model_en && mb != '0) begin
                model_done <= 1'b1;
                div_m      <= SIZE'(int'(ma) / int'(mb));
                div_f      <= 10'(((int'(ma) % int'(mb)) * 1000) / int'(mb));
                div_err    <= 1'b0;
            end
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end
    end

    // Scoreboard monitor: every done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (div_start) starts = starts + 1;
            if (div_done) dd_cyc = cyc;
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_onehot", int'(done), 1 << mon_e.idx);
                    check("gnt_in_return", int'(gnt), 1 << mon_e.idx);
                    check("res_m", int'(res_m), mon_e.m);
                    check("res_f", int'(res_f), mon_e.f);
                    check("res_err", int'(res_err), mon_e.err);
                end
            end
        end
    end

    task automatic drive(input int idx, input int a, input int b);
        req[idx]                 = 1'b1;
        req_a[idx*SIZE +: SIZE] = SIZE'(a);
        req_b[idx*SIZE +: SIZE] = SIZE'(b);
    endtask

    task automatic wait_done(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (done != '0) got = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, int'(gnt), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_div_start"}, int'(div_start), 0);
        check({tag, "_div_a"}, int'(div_a), 0);
        check({tag, "_div_b"}, int'(div_b), 0);
        check({tag, "_res_m"}, int'(res_m), 0);
        check({tag, "_res_f"}, int'(res_f), 0);
        check({tag, "_res_err"}, int'(res_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit got;
        int s0;
        int c0;
        int ci;
        int rc;

        tbl[0] = '{0, 9, 4, 2, 250, 0};
        tbl[1] = '{1, 7, 3, 2, 333, 0};
        tbl[2] = '{2, 5, 0, 0, 0, 1};
        tbl[3] = '{3, 15, 2, 7, 500, 0};
        tbl[4] = '{0, 3, 8, 0, 375, 0};
        tbl[5] = '{1, 15, 15, 1, 0, 0};
        tbl[6] = '{2, 1, 7, 0, 142, 0};
        tbl[7] = '{3, 0, 5, 0, 0, 0};

        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation 9/4 with full timing checks.
        s0 = starts;
        drive(0, 9, 4);
        sb.push_back('{0, 2, 250, 0});
        @(negedge clk);
        check("issue_gnt", int'(gnt), 1);
        check("issue_div_start", int'(div_start), 1);
        check("issue_div_a", int'(div_a), 9);
        check("issue_div_b", int'(div_b), 4);
        wait_done(40, got);
        if (!got) check("basic_done_seen", 0, 1);
        check("done_one_after_div_done", cyc - dd_cyc, 1);
        check("basic_single_start", starts - s0, 1);
        req = '0;
        @(negedge clk);
        check("gnt_released", int'(gnt), 0);
        check("div_a_cleared", int'(div_a), 0);

        // Stray div_done while idle must not disturb the held result.
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_res_m", int'(res_m), 2);
        check("stray_res_f", int'(res_f), 250);
        check("stray_res_err", int'(res_err), 0);

        for (int i = 0; i < 8; i++) begin
            s0 = starts;
            drive(tbl[i].idx, tbl[i].a, tbl[i].b);
            sb.push_back('{tbl[i].idx, tbl[i].m, tbl[i].f, tbl[i].err});
            wait_done(40, got);
            if (!got) check("table_done_seen", 0, 1);
            check("table_start_count", starts - s0, (tbl[i].b != 0) ? 1 : 0);
            req = '0;
            @(negedge clk);
        end

        // Divide by zero: no start, done two cycles after the sampling edge.
        s0 = starts;
        c0 = cyc;
        drive(2, 5, 0);
        sb.push_back('{2, 0, 0, 1});
        @(negedge clk);
        check("dz_issue_gnt", int'(gnt), 4);
        check("dz_no_start", int'(div_start), 0);
        wait_done(10, got);
        if (!got) check("dz_done_seen", 0, 1);
        check("dz_latency", cyc - c0, 2);
        check("dz_start_count", starts - s0, 0);
        req = '0;
        @(negedge clk);

        // Round robin from reset with all requesters held.
        pulse_reset();
        req   = '1;
        req_a = {4'd8, 4'd7, 4'd6, 4'd5};
        req_b = {4'd4, 4'd3, 4'd2, 4'd1};
        sb.push_back('{0, 5, 0, 0});
        sb.push_back('{1, 3, 0, 0});
        sb.push_back('{2, 2, 333, 0});
        sb.push_back('{3, 2, 0, 0});
        sb.push_back('{0, 5, 0, 0});
        for (int i = 0; i < 5; i++) begin
            wait_done(40, got);
            if (!got) check("rr_done_seen", 0, 1);
        end
        req = '0;
        repeat (6) @(negedge clk);
        check("rr_queue_drained", sb.size(), 0);
        check("rr_idle_gnt", int'(gnt), 0);

        // Reset during WAIT aborts the operation; the late div_done is ignored.
        req_a = '0;
        req_b = '0;
        model_delay = 8;
        drive(1, 7, 3);
        repeat (3) @(negedge clk);
        check("abort_in_wait_gnt", int'(gnt), 2);
        rc = cyc;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("late_div_done_seen", (dd_cyc > rc) ? 1 : 0, 1);
        check_all_zero("after_abort");
        model_delay = 5;

        // Divider never answers.
        model_en = 1'b0;
        drive(0, 9, 4);
        @(negedge clk);
        ci = cyc;
        check("hang_issue_gnt", int'(gnt), 1);
`ifdef DIV_ARB_TIMEOUT_EN
        sb.push_back('{0, 0, 0, 1});
        wait_done(30, got);
        if (!got) check("watchdog_done_seen", 0, 1);
        check("watchdog_latency", cyc - ci, TMO + 1);
        req = '0;
        repeat (2) @(negedge clk);
`else
        repeat (40) @(negedge clk);
        check("hang_gnt_held", int'(gnt), 1);
        check("hang_no_done", int'(done), 0);
        req = '0;
        pulse_reset();
`endif
        model_en = 1'b1;
        check("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter SIZE, default 4: operand and integer-quotient width in bits, matching the shared divider.
REQ-002 Parameter NREQ, default 4: number of requesters, 2 to 8.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent waiting for divider completion (used only when the watchdog is compiled in).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester request level; held until the matching done pulse.
REQ-007 req_a  input  NREQ*SIZE  dividend for requester i, in bits [i*SIZE +: SIZE].
REQ-008 req_b  input  NREQ*SIZE  divisor for requester i, in bits [i*SIZE +: SIZE].
REQ-009 gnt  output  NREQ  one-hot grant, high for the whole operation of the served requester.
REQ-010 done  output  NREQ  one-cycle completion pulse to the served requester.
REQ-011 res_m  output  SIZE  integer quotient of the last completed operation.
REQ-012 res_f  output  10  three-digit decimal fraction (0..999) of the last completed operation.
REQ-013 res_err  output  1  error flag of the last completed operation.
REQ-014 div_start  output  1  one-cycle start pulse to the divider.
REQ-015 div_a, div_b  output  SIZE each  operands presented to the divider.
REQ-016 div_done  input  1  divider completion pulse.
REQ-017 div_m  input  SIZE, div_f  input  10, div_err  input  1  divider result, valid while div_done is high.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RETURN.
REQ-019 IDLE, any req bit high: pick the winner round-robin, searching from (last served index + 1) mod NREQ upward; latch the winner's req_a and req_b; go to ISSUE.
REQ-020 ISSUE: gnt[winner] goes high; if latched b is nonzero, assert div_start for exactly this cycle and go to WAIT; if latched b is 0, do not assert div_start and go directly to RETURN with res_err=1, res_m=0, res_f=0.
REQ-021 div_a and div_b SHALL carry the latched operands from ISSUE through WAIT, and hold 0 otherwise.
REQ-022 WAIT: on div_done, capture div_m, div_f and div_err into the result registers and go to RETURN.
REQ-023 div_done SHALL be ignored in every state except WAIT.
REQ-024 RETURN: done[winner] is high for one cycle; the last-served pointer updates to the winner; next state is IDLE.
REQ-025 gnt[winner] falls on the cycle after RETURN.
REQ-026 Latency: req sampled in IDLE at cycle N gives ISSUE and div_start at N+1; div_done at cycle D gives done at D+1; IDLE is reached at D+2.
REQ-027 req bits are evaluated only in IDLE; a requester whose req is still high after its done is treated as a new request.
REQ-028 A winner that drops req mid-operation still completes: done is pulsed and results are updated.
REQ-029 res_m, res_f and res_err SHALL hold their values until the next RETURN.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE; gnt, done, div_start, div_a, div_b, res_m, res_f and res_err all 0; last-served pointer NREQ-1, so requester 0 has first priority.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse; any later div_done is ignored.

Configuration
REQ-032 With macro DIV_ARB_TIMEOUT_EN defined, a WAIT cycle counter runs, cleared on WAIT entry.
REQ-033 With DIV_ARB_TIMEOUT_EN defined, after TIMEOUT cycles in WAIT without div_done the FSM goes to RETURN with res_err=1, res_m=0, res_f=0.
REQ-034 With DIV_ARB_TIMEOUT_EN undefined, no counter exists and WAIT exits only on div_done.

Verification
REQ-035 req=0001, a0=9, b0=4; divider model returns m=2, f=250 after 5 cycles -> gnt=0001, single div_start, done=0001, res_m=2, res_f=250, res_err=0.
REQ-036 req=1111 held continuously -> grants served in order 0,1,2,3,0, with exactly one done per grant.
REQ-037 req=0100, b2=0 -> no div_start, done=0100 two cycles after the request is sampled, res_err=1, res_m=0, res_f=0.
REQ-038 rst_n pulsed low during WAIT, then div_done arrives -> no done pulse, all outputs 0, FSM in IDLE.
REQ-039 DIV_ARB_TIMEOUT_EN defined, TIMEOUT=10, divider never completes -> done 11 cycles after ISSUE with res_err=1; undefined -> gnt stays high indefinitely.
REQ-040 Stray div_done pulse in IDLE -> res_m, res_f and res_err unchanged and no done pulse.
